// File: rtl/ex_stage.sv
// Execute stage + EX/MEM pipeline register: ALU, branch/jump resolution, shift-add multiply.
// Latency: ALU ops 1 cycle into M; multiply occupies EX for 33 cycles, result on the 33rd edge.
// Backpressure: BusyE asks the hazard unit to hold fetch/decode/ID-EX; bubbles go to M meanwhile.
//
// Ports:
//   clk, reset (async, active-low)
//   E-stage inputs : RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE, MulE,
//                    RD1E, RD2E, PCE, RdE, ImmExtE, PCPlus4E
//   E-stage outputs: PCSrcE, PCTargetE, BusyE (combinational)
//   M-stage outputs: RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M
module ex_stage #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic [2:0]      ALUControlE,
  input  logic            ALUSrcE,
  input  logic            MulE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [4:0]      RdE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            BusyE,
  output logic            RegWriteM,
  output logic [1:0]      ResultSrcM,
  output logic            MemWriteM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] PCPlus4M
);

  localparam int CW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MUL_CYCLES - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  logic [0:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic [XLEN-1:0] acc_next;
  logic            mul_last;

  assign src_a = RD1E;
  assign src_b = ALUSrcE ? ImmExtE : RD2E;

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b100:  alu_result = src_a ^ src_b;
      3'b101:  alu_result = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_result = '0;
    endcase
  end

  assign zero      = (alu_result == '0);
  assign PCTargetE = PCE + ImmExtE;

  // One partial-product bit per cycle; the sum wraps to XLEN bits.
  assign acc_next = acc + (mplier[0] ? mcand : '0);
  assign mul_last = (state == S_MUL) && (cnt == CNT_LAST);

  // Busy covers the entry cycle plus every MUL cycle except the last, so the
  // instruction behind the multiply can advance into ID/EX as the result lands in M.
  assign BusyE  = ((state == S_IDLE) && MulE) || ((state == S_MUL) && !mul_last);

  // A multiply never redirects fetch, even when its (ignored) jump/branch bits are set.
  assign PCSrcE = ((BranchE && zero) || JumpE) && !MulE && (state != S_MUL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (MulE) begin
            mcand  <= src_a;
            mplier <= src_b;
            acc    <= '0;
            cnt    <= '0;
            state  <= S_MUL;
          end
        end
        default: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (mul_last) begin
            state <= S_IDLE;
          end
        end
      endcase
    end
  end

  // EX/MEM register. Bubbles only clear the write enables; the remaining
  // fields hold their previous contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
      PCPlus4M   <= '0;
    end else if ((state == S_IDLE) && !MulE) begin
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      ALUResultM <= alu_result;
      WriteDataM <= RD2E;
      RdM        <= RdE;
      PCPlus4M   <= PCPlus4E;
    end else if (mul_last) begin
      // E inputs are still held by the hazard unit, so they describe the multiply.
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      ALUResultM <= acc_next;
      WriteDataM <= RD2E;
      RdM        <= RdE;
      PCPlus4M   <= PCPlus4E;
    end else begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: directed and randomized ALU, branch, multiply and reset scenarios.
// Expected values come from a plain-arithmetic reference model of the instruction semantics.
// Inputs change 1 time unit after the rising edge; outputs are sampled there as well.
module tb_ex_stage;

  logic        clk;
  logic        reset;
  logic        RegWriteE;
  logic [1:0]  ResultSrcE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic [2:0]  ALUControlE;
  logic        ALUSrcE;
  logic        MulE;
  logic [31:0] RD1E;
  logic [31:0] RD2E;
  logic [31:0] PCE;
  logic [4:0]  RdE;
  logic [31:0] ImmExtE;
  logic [31:0] PCPlus4E;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        BusyE;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [4:0]  RdM;
  logic [31:0] PCPlus4M;

  int checks = 0;
  int errors = 0;

  ex_stage #(.XLEN(32), .MUL_CYCLES(32)) dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .MulE(MulE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .RdE(RdE), .ImmExtE(ImmExtE),
    .PCPlus4E(PCPlus4E), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference semantics of the ALU operations.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int signed sa;
    int signed sb;
    sa = a;
    sb = b;
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_imm, input logic [31:0] imm, input logic [4:0] rd,
                         input logic rw);
    MulE        = 1'b0;
    ALUControlE = op;
    RD1E        = a;
    RD2E        = b;
    ALUSrcE     = use_imm;
    ImmExtE     = imm;
    RdE         = rd;
    RegWriteE   = rw;
    BranchE     = 1'b0;
    JumpE       = 1'b0;
    MemWriteE   = 1'b0;
    ResultSrcE  = 2'b00;
  endtask

  task automatic randomize_e();
    RegWriteE   = 1'($urandom);
    ResultSrcE  = 2'($urandom);
    MemWriteE   = 1'($urandom);
    JumpE       = 1'($urandom);
    BranchE     = 1'($urandom);
    ALUControlE = 3'($urandom);
    ALUSrcE     = 1'($urandom);
    RD1E        = $urandom;
    RD2E        = $urandom;
    PCE         = $urandom;
    RdE         = 5'($urandom);
    ImmExtE     = $urandom;
    PCPlus4E    = $urandom;
  endtask

  // Issues a multiply and walks it to completion, checking busy length, bubbles and product.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd);
    int k;
    logic [31:0] prod;
    prod        = a * b;
    MulE        = 1'b1;
    RD1E        = a;
    RD2E        = b;
    ALUSrcE     = 1'b0;
    RegWriteE   = 1'b1;
    RdE         = rd;
    ALUControlE = 3'($urandom);
    JumpE       = 1'b1;
    BranchE     = 1'b1;
    PCPlus4E    = $urandom;
    #1;
    check({tag, "_pcsrc_forced0"}, 32'(PCSrcE), 32'd0);
    k = 0;
    while (BusyE && k < 40) begin
      k++;
      tick();
      check({tag, "_bubble_regwrite"}, 32'(RegWriteM), 32'd0);
    end
    check({tag, "_busy_cycles"}, k, 32);
    tick();
    check({tag, "_product"}, ALUResultM, prod);
    check({tag, "_regwrite"}, 32'(RegWriteM), 32'd1);
    check({tag, "_rd"}, 32'(RdM), 32'(rd));
    MulE  = 1'b0;
    JumpE = 1'b0;
    BranchE = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_pcsrc;

    // Reset held with random E inputs (non-multiply so the stall request stays low).
    reset = 1'b0;
    randomize_e();
    MulE = 1'b0;
    repeat (3) tick();
    check("rst_regwrite", 32'(RegWriteM), 32'd0);
    check("rst_resultsrc", 32'(ResultSrcM), 32'd0);
    check("rst_memwrite", 32'(MemWriteM), 32'd0);
    check("rst_aluresult", ALUResultM, 32'd0);
    check("rst_writedata", WriteDataM, 32'd0);
    check("rst_rd", 32'(RdM), 32'd0);
    check("rst_pcplus4", PCPlus4M, 32'd0);
    check("rst_busy", 32'(BusyE), 32'd0);
    check("rst_pctarget", PCTargetE, PCE + ImmExtE);

    reset = 1'b1;
    exp_res = alu_ref(ALUControlE, RD1E, ALUSrcE ? ImmExtE : RD2E);
    tick();
    check("post_rst_aluresult", ALUResultM, exp_res);
    check("post_rst_rd", 32'(RdM), 32'(RdE));
    check("post_rst_pcplus4", PCPlus4M, PCPlus4E);

    // Directed ALU operations.
    set_alu(3'b001, 32'd5, 32'd7, 1'b0, 32'd0, 5'd3, 1'b1);
    tick();
    check("sub_result", ALUResultM, 32'hFFFF_FFFE);
    check("sub_rd", 32'(RdM), 32'd3);
    check("sub_regwrite", 32'(RegWriteM), 32'd1);
    set_alu(3'b101, 32'd5, 32'd7, 1'b0, 32'd0, 5'd3, 1'b1);
    tick();
    check("slt_result", ALUResultM, 32'd1);
    set_alu(3'b000, 32'd5, 32'd7, 1'b1, 32'h10, 5'd3, 1'b1);
    tick();
    check("addi_result", ALUResultM, 32'h15);

    // Branch and jump resolution.
    set_alu(3'b001, 32'd9, 32'd9, 1'b0, 32'hFFFF_FFF8, 5'd0, 1'b0);
    PCE     = 32'h100;
    BranchE = 1'b1;
    #1;
    check("beq_taken", 32'(PCSrcE), 32'd1);
    check("beq_target", PCTargetE, 32'hF8);
    RD2E = 32'd8;
    #1;
    check("beq_not_taken", 32'(PCSrcE), 32'd0);
    JumpE = 1'b1;
    #1;
    check("jump_taken", 32'(PCSrcE), 32'd1);
    tick();

    // Multiplies, including wrap cases and a back-to-back add.
    do_mul("mul_7x6", 32'd7, 32'd6, 5'd9);
    do_mul("mul_wrap1", 32'hFFFF_FFFF, 32'd2, 5'd10);
    do_mul("mul_wrap2", 32'h8000_0000, 32'h8000_0000, 5'd11);
    set_alu(3'b000, 32'd100, 32'd23, 1'b0, 32'd0, 5'd12, 1'b1);
    #1;
    check("b2b_busy", 32'(BusyE), 32'd0);
    tick();
    check("b2b_add", ALUResultM, 32'd123);
    check("b2b_rd", 32'(RdM), 32'd12);

    // Randomized ALU traffic, with frequent equal operands to exercise ZeroE.
    for (int i = 0; i < 30; i++) begin
      randomize_e();
      MulE = 1'b0;
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      RD1E = a;
      if (ALUSrcE) ImmExtE = b;
      else         RD2E    = b;
      exp_res   = alu_ref(ALUControlE, a, b);
      exp_pcsrc = JumpE | (BranchE & (exp_res == 32'd0));
      #1;
      check("rnd_pcsrc", 32'(PCSrcE), 32'(exp_pcsrc));
      check("rnd_pctarget", PCTargetE, PCE + ImmExtE);
      check("rnd_busy", 32'(BusyE), 32'd0);
      tick();
      check("rnd_result", ALUResultM, exp_res);
      check("rnd_writedata", WriteDataM, RD2E);
      check("rnd_ctrl", {27'd0, RegWriteM, ResultSrcM, MemWriteM, 1'b0},
            {27'd0, RegWriteE, ResultSrcE, MemWriteE, 1'b0});
      check("rnd_rd", 32'(RdM), 32'(RdE));
      check("rnd_pcplus4", PCPlus4M, PCPlus4E);
    end

    // Randomized multiplies.
    for (int i = 0; i < 4; i++) begin
      a = $urandom;
      b = $urandom;
      do_mul("rnd_mul", a, b, 5'($urandom_range(1, 31)));
    end

    // Reset in the middle of a multiply.
    MulE      = 1'b1;
    RD1E      = 32'd1234;
    RD2E      = 32'd5678;
    ALUSrcE   = 1'b0;
    RegWriteE = 1'b1;
    RdE       = 5'd7;
    repeat (11) tick();
    check("midrst_busy_before", 32'(BusyE), 32'd1);
    reset = 1'b0;
    #1;
    check("midrst_regwrite", 32'(RegWriteM), 32'd0);
    check("midrst_aluresult", ALUResultM, 32'd0);
    check("midrst_writedata", WriteDataM, 32'd0);
    check("midrst_rd", 32'(RdM), 32'd0);
    check("midrst_pcplus4", PCPlus4M, 32'd0);
    MulE = 1'b0;
    #1;
    check("midrst_busy", 32'(BusyE), 32'd0);
    tick();
    reset = 1'b1;
    set_alu(3'b000, 32'd40, 32'd2, 1'b0, 32'd0, 5'd5, 1'b1);
    tick();
    check("midrst_add", ALUResultM, 32'd42);
    check("midrst_add_rd", 32'(RdM), 32'd5);
    check("midrst_add_regwrite", 32'(RegWriteM), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
Execute stage and EX/MEM pipeline register. It consumes the E-stage control and data signals produced by the ID/EX register and performs the ALU operation. It also resolves branches and jumps back to fetch. Single-cycle ALU ops register into the M stage in one cycle; a multi-cycle shift-add multiply holds the EX stage and emits bubbles downstream until the product is ready.

Parameters:
XLEN, 32, datapath width
MUL_CYCLES, 32, multiply iterations, one partial-product bit per cycle; must equal XLEN

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
RegWriteE  in  1  register-file write enable for this instruction
ResultSrcE  in  2  writeback result select, passed through
MemWriteE  in  1  data-memory write enable
JumpE  in  1  jal/jalr instruction
BranchE  in  1  beq instruction
ALUControlE  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt (signed); 110/111 give 0
ALUSrcE  in  1  1 = SrcB is ImmExtE, 0 = SrcB is RD2E
MulE  in  1  1 = multiply (low XLEN bits of SrcA*SrcB); ALUControlE is ignored
RD1E, RD2E  in  32  register operands
PCE  in  32  instruction PC
RdE  in  5  destination register
ImmExtE  in  32  extended immediate
PCPlus4E  in  32  PC+4
PCSrcE  out  1  comb: (BranchE & ZeroE) | JumpE; forced 0 while a multiply is in progress
PCTargetE  out  32  comb: PCE + ImmExtE
BusyE  out  1  comb: stall request to the hazard unit; fetch, decode and ID/EX must hold
RegWriteM, ResultSrcM[2], MemWriteM  out  -  registered control
ALUResultM  out  32  registered ALU/multiply result
WriteDataM  out  32  registered RD2E
RdM  out  5  registered destination
PCPlus4M  out  32  registered PC+4

Behaviour:
- SrcA = RD1E; SrcB = ALUSrcE ? ImmExtE : RD2E. ZeroE = (ALU result == 0). Add/sub wrap modulo 2^32. slt is signed and yields 0 or 1.
- FSM states IDLE and MUL. A 5-bit counter cnt, plus registers mcand, mplier and acc (32 bits each).
- IDLE, MulE=0: every clock loads the EX/MEM register from the E inputs and the ALU result. BusyE=0. Latency is 1 cycle.
- IDLE, MulE=1: BusyE=1. On the clock edge: mcand<=SrcA, mplier<=SrcB, acc<=0, cnt<=0, go to MUL. The EX/MEM register loads a bubble: RegWriteM=0, MemWriteM=0, other M fields don't-care but deterministic (hold).
- MUL: each cycle computes acc_next = acc + (mplier[0] ? mcand : 0), then mcand<<=1, mplier>>=1, cnt++. Products wrap to the low 32 bits.
  - While cnt<31: BusyE=1 and the EX/MEM register loads a bubble.
  - When cnt==31: BusyE=0. The EX/MEM register loads ALUResultM=acc_next, with the other M fields taken from the still-held E inputs. Go to IDLE.
  - Total EX occupancy is 33 cycles; BusyE is high for 32 consecutive cycles.
- E inputs are required stable during MUL because the hazard unit holds ID/EX on BusyE. The FSM latches operands only at entry.
- PCSrcE is 0 whenever state==MUL or MulE=1. Multiply never redirects fetch.
- Reset (reset==0, async): state=IDLE, cnt=0, mcand/mplier/acc=0. All M outputs=0 (RegWriteM=0, ResultSrcM=00, MemWriteM=0, ALUResultM=0, WriteDataM=0, RdM=0, PCPlus4M=0). Reset asserted mid-multiply abandons the operation. After release the block starts in IDLE and evaluates whatever the E inputs hold.
- Combinational outputs (PCSrcE, PCTargetE, BusyE) depend only on E inputs and FSM state, and are valid under reset.

Test Plan:
- Reset: hold reset=0 with random E inputs -> all M outputs 0, BusyE=0. Release -> first edge registers the E inputs.
- ALU: RD1E=5, RD2E=7, ALUControlE=001, RegWriteE=1, RdE=3 -> next cycle ALUResultM=0xFFFFFFFE, RdM=3, RegWriteM=1. Repeat with 101 -> ALUResultM=1. Repeat with ALUSrcE=1, ImmExtE=0x10, add -> 0x15.
- Branch/jump: BranchE=1, RD1E=RD2E=9, sub, PCE=0x100, ImmExtE=0xFFFFFFF8 -> PCSrcE=1, PCTargetE=0xF8. Set RD2E=8 -> PCSrcE=0. JumpE=1 -> PCSrcE=1 regardless of ZeroE.
- Multiply: MulE=1, RD1E=7, RD2E=6 -> BusyE high exactly 32 cycles, RegWriteM=0 throughout. In cycle 33, ALUResultM=42 with RegWriteM/RdM from the E inputs.
- Multiply wrap: 0xFFFFFFFF * 2 -> ALUResultM=0xFFFFFFFE. 0x80000000 * 0x80000000 -> 0. Back-to-back: a following add issues the cycle after completion with 1-cycle latency.
- Reset mid-multiply: assert reset at cycle 10 of MUL -> BusyE=0, all M outputs 0 immediately. After release with MulE=0 and an add -> normal 1-cycle result.
